// File: rtl/clz_normalizer.sv
// Multi-cycle CLZ/CLO normaliser: counts leading zeros or ones and left-justifies the operand.
// Ports: clk, rstn, start/operand/count_ones in; busy, done, count, norm, all_same out.
module clz_normalizer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    input  logic             count_ones,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] norm,
    output logic             all_same
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_w;
    logic [WIDTH-1:0] r_s;
    logic [CNT_W-1:0] r_c;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_norm;
    logic             r_all_same;

    logic w_full;
    logic w_hit;

    // Scan copy is pre-inverted for CLO, so the search is always for a 1.
    // The full-count test also stops the scan on an all-zero scan copy.
    assign w_full = (r_c == CNT_W'(WIDTH));
    assign w_hit  = r_w[WIDTH-1] | w_full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = start ? SCAN : IDLE;
            SCAN:    w_next = w_hit ? DONE : SCAN;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == SCAN);
        done = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_w        <= '0;
            r_s        <= '0;
            r_c        <= '0;
            r_count    <= '0;
            r_norm     <= '0;
            r_all_same <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_w <= operand ^ {WIDTH{count_ones}};
                r_s <= operand;
                r_c <= '0;
            end else if (r_state == SCAN) begin
                if (w_hit) begin
                    r_count    <= r_c;
                    r_norm     <= r_s;
                    r_all_same <= w_full;
                end else begin
                    r_w <= r_w << 1;
                    r_s <= r_s << 1;
                    r_c <= r_c + 1'b1;
                end
            end
        end
    end

    assign count    = r_count;
    assign norm     = r_norm;
    assign all_same = r_all_same;

endmodule

// File: tb/tb_clz_normalizer.sv
// Self-checking bench for clz_normalizer: vector table plus busy-start and reset-abort sequences.
// Drives on negedge / #1 after posedge, samples 1 time unit after the rising edge.
module tb_clz_normalizer;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [31:0] operand;
    logic        count_ones;
    logic        busy;
    logic        done;
    logic [5:0]  count;
    logic [31:0] norm;
    logic        all_same;

    int checks = 0;
    int errors = 0;

    clz_normalizer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .operand(operand),
        .count_ones(count_ones),
        .busy(busy),
        .done(done),
        .count(count),
        .norm(norm),
        .all_same(all_same)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op;
        logic        ones;
        int          cnt;
        logic [31:0] nrm;
        logic        as;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_zero(input string nm);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_done"}, {31'd0, done}, 32'd0);
        chk({nm, "_count"}, {26'd0, count}, 32'd0);
        chk({nm, "_norm"}, norm, 32'd0);
        chk({nm, "_all_same"}, {31'd0, all_same}, 32'd0);
    endtask

    // Start one operation and check latency, busy, results and single pulse.
    task automatic run_op(input logic [31:0] op, input logic ones,
                          input int ecnt, input logic [31:0] enrm,
                          input logic eas, input string nm);
        int lat;
        @(negedge clk);
        start      = 1'b1;
        operand    = op;
        count_ones = ones;
        @(posedge clk);
        #1;
        start      = 1'b0;
        operand    = $urandom;
        count_ones = ~ones;
        chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, ecnt + 1);
        chk({nm, "_count"}, {26'd0, count}, ecnt);
        chk({nm, "_norm"}, norm, enrm);
        chk({nm, "_all_same"}, {31'd0, all_same}, {31'd0, eas});
        chk({nm, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({nm, "_hold_norm"}, norm, enrm);
    endtask

    initial begin
        int pulses;
        logic [5:0]  seen_cnt;
        logic [31:0] seen_nrm;

        tv[0]  = '{32'h8000_0000, 1'b0, 0,  32'h8000_0000, 1'b0};
        tv[1]  = '{32'h0000_F000, 1'b0, 16, 32'hF000_0000, 1'b0};
        tv[2]  = '{32'h0000_0000, 1'b0, 32, 32'h0000_0000, 1'b1};
        tv[3]  = '{32'hFFFF_FFFF, 1'b1, 32, 32'h0000_0000, 1'b1};
        tv[4]  = '{32'h0000_0001, 1'b0, 31, 32'h8000_0000, 1'b0};
        tv[5]  = '{32'h7FFF_FFFF, 1'b1, 0,  32'h7FFF_FFFF, 1'b0};
        tv[6]  = '{32'h0000_0001, 1'b1, 0,  32'h0000_0001, 1'b0};
        tv[7]  = '{32'h4000_0000, 1'b0, 1,  32'h8000_0000, 1'b0};
        tv[8]  = '{32'hC000_0001, 1'b1, 2,  32'h0000_0004, 1'b0};
        tv[9]  = '{32'hFFFF_FFFE, 1'b1, 31, 32'h0000_0000, 1'b0};
        tv[10] = '{32'hFF0F_0000, 1'b1, 8,  32'h0F00_0000, 1'b0};
        tv[11] = '{32'h0012_3456, 1'b0, 11, 32'h91A2_B000, 1'b0};

        rstn       = 1'b0;
        start      = 1'b0;
        operand    = '0;
        count_ones = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk_idle_zero($sformatf("reset_idle%0d", i));
        end

        foreach (tv[i]) begin
            run_op(tv[i].op, tv[i].ones, tv[i].cnt, tv[i].nrm, tv[i].as,
                   $sformatf("vec%0d", i));
        end

        // Starts pulsed while busy must be ignored.
        @(negedge clk);
        start      = 1'b1;
        operand    = 32'hFF0F_0000;
        count_ones = 1'b1;
        pulses     = 0;
        seen_cnt   = '0;
        seen_nrm   = '0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                seen_cnt = count;
                seen_nrm = norm;
            end
            start      = (k >= 1 && k <= 5);
            operand    = 32'h0000_0001 << k;
            count_ones = k[0];
        end
        start = 1'b0;
        chk("busy_start_pulses", pulses, 32'd1);
        chk("busy_start_count", {26'd0, seen_cnt}, 32'd8);
        chk("busy_start_norm", seen_nrm, 32'h0F00_0000);
        chk("busy_start_final_busy", {31'd0, busy}, 32'd0);

        // Reset ten cycles into a scan aborts with no done pulse.
        @(negedge clk);
        start      = 1'b1;
        operand    = 32'h0000_0001;
        count_ones = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        chk_idle_zero("abort_reset");
        @(negedge clk);
        rstn   = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        chk("abort_no_done", pulses, 32'd0);
        run_op(32'h0000_0001, 1'b0, 31, 32'h8000_0000, 1'b0, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
